// File: rtl/pc_sequencer.sv
// Program-counter / fetch sequencer with run, halt and branch resolution plus a taken-branch bubble.
// Optional retired-instruction counter enabled by defining PC_SEQ_INSTCNT_EN.
module pc_sequencer #(
  parameter int unsigned PC_W       = 10,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned OFF_W      = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             branch,
  input  logic             is_abs,
  input  logic             flag,
  input  logic [7:0]       target,
  input  logic [OFF_W-1:0] rel_off,
  output logic [PC_W-1:0]  pc,
  output logic             fetch_valid,
  output logic             done
`ifdef PC_SEQ_INSTCNT_EN
  ,
  output logic [15:0]      inst_count
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StBubble, StHalt} state_e;

  localparam logic [PC_W-1:0] StartPc = PC_W'(START_ADDR);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            fetch_valid_q, fetch_valid_d;
  logic            done_q, done_d;
  logic [PC_W-1:0] rel_ext;
  logic [PC_W-1:0] br_target;

  // Sign-extend (or truncate) the offset so the add wraps modulo 2^PC_W.
  assign rel_ext   = PC_W'($signed(rel_off));
  assign br_target = is_abs ? PC_W'(target) : pc_q + rel_ext;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (start) begin
      state_d = StRun;
      pc_d    = StartPc;
    end else begin
      unique case (state_q)
        StIdle: ;
        StRun: begin
          if (!stall) begin
            if (halt_req) begin
              state_d = StHalt;
            end else if (branch && flag) begin
              state_d = StBubble;
              pc_d    = br_target;
            end else begin
              pc_d = pc_q + PC_W'(1);
            end
          end
        end
        StBubble: begin
          if (!stall) state_d = StRun;
        end
        StHalt: ;
        default: state_d = StIdle;
      endcase
    end
    fetch_valid_d = (state_d == StRun);
    done_d        = (state_d == StHalt);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= StIdle;
      pc_q          <= StartPc;
      fetch_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      done_q        <= done_d;
    end
  end

  assign pc          = pc_q;
  assign fetch_valid = fetch_valid_q;
  assign done        = done_q;

`ifdef PC_SEQ_INSTCNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (state_q == StRun && !stall && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign inst_count = cnt_q;
`endif

endmodule
